arm_pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage ARM pipeline. It sits beside the forwarding unit and handles the hazards that forwarding cannot cover:
- load-use interlock
- multi-cycle MAC occupancy of EX
- taken-branch flush
- SWI/halt drain
It drives the PC, IF/ID and ID/EX pipeline-register controls and keeps a stall-cycle performance counter.

---
 rtl/arm_pipe_ctrl_pkg.sv | 33 +++
 rtl/arm_pipe_ctrl_if.sv | 41 ++++
 rtl/arm_load_use_detect.sv | 20 ++
 rtl/arm_pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_arm_pipe_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/arm_pipe_ctrl_pkg.sv
// rtl/arm_pipe_ctrl_pkg.sv - shared types and defaults for the pipeline stall/flush sequencer
package arm_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MAC_WAIT   = 2'd1,
        ST_HALT_DRAIN = 2'd2,
        ST_HALTED     = 2'd3
    } pipe_state_t;

    localparam int DEF_MAC_LAT      = 3;
    localparam int DEF_DRAIN_CYCLES = 3;
    localparam int DEF_CNT_W        = 16;
    localparam int RS_SLOTS         = 3;

    typedef logic [3:0]                 reg_num_t;
    typedef reg_num_t [RS_SLOTS-1:0]    rs_nums_t;
    typedef logic [RS_SLOTS-1:0]        rs_mask_t;

    // True when any live source slot names the given register.
    function automatic logic reads_reg(input rs_nums_t nums, input rs_mask_t mask,
                                       input reg_num_t rd);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < RS_SLOTS; i++) begin
            if (mask[i] && (nums[i] == rd)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/arm_pipe_ctrl_if.sv
// rtl/arm_pipe_ctrl_if.sv - hazard inputs and pipeline control outputs of the sequencer
interface arm_pipe_ctrl_if
    import arm_pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             id_valid;
    rs_nums_t         id_rs_num;
    rs_mask_t         id_rs_mask;
    logic             id_is_mac;
    logic             id_is_halt;
    logic             ex_valid;
    logic             ex_is_load;
    logic             ex_rd_we;
    reg_num_t         ex_rd_num;
    logic             ex_branch_taken;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             ex_hold;
    logic             mac_busy;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        input  id_valid, id_rs_num, id_rs_mask, id_is_mac, id_is_halt,
        input  ex_valid, ex_is_load, ex_rd_we, ex_rd_num, ex_branch_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold,
        output mac_busy, halted, stall_count
    );

    modport slave (
        output id_valid, id_rs_num, id_rs_mask, id_is_mac, id_is_halt,
        output ex_valid, ex_is_load, ex_rd_we, ex_rd_num, ex_branch_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold,
        input  mac_busy, halted, stall_count
    );

endinterface

// File: rtl/arm_load_use_detect.sv
// rtl/arm_load_use_detect.sv - combinational load-use hazard detector between ID and EX
module arm_load_use_detect
    import arm_pipe_ctrl_pkg::*;
(
    input  logic     id_valid,
    input  rs_nums_t id_rs_num,
    input  rs_mask_t id_rs_mask,
    input  logic     ex_valid,
    input  logic     ex_is_load,
    input  logic     ex_rd_we,
    input  reg_num_t ex_rd_num,
    output logic     load_use
);

    logic ex_load_dest;

    assign ex_load_dest = ex_valid & ex_is_load & ex_rd_we;
    assign load_use     = ex_load_dest & id_valid & reads_reg(id_rs_num, id_rs_mask, ex_rd_num);

endmodule

// File: rtl/arm_pipe_ctrl.sv
// rtl/arm_pipe_ctrl.sv - stall/flush sequencer for load-use, MAC occupancy, branch flush and halt drain
module arm_pipe_ctrl
    import arm_pipe_ctrl_pkg::*;
#(
    parameter int MAC_LAT      = DEF_MAC_LAT,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    arm_pipe_ctrl_if.master bus
);

    localparam int MC_W = $clog2(MAC_LAT + 1);
    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

    pipe_state_t      state, nxt_state;
    logic [MC_W-1:0]  mac_cnt, nxt_mac_cnt;
    logic [DC_W-1:0]  drain_cnt, nxt_drain_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use;

    logic c_pc_stall, c_ifid_stall, c_ifid_flush, c_idex_bubble;
    logic c_ex_hold, c_mac_busy, c_halted;

    arm_load_use_detect u_load_use (
        .id_valid   (bus.id_valid),
        .id_rs_num  (bus.id_rs_num),
        .id_rs_mask (bus.id_rs_mask),
        .ex_valid   (bus.ex_valid),
        .ex_is_load (bus.ex_is_load),
        .ex_rd_we   (bus.ex_rd_we),
        .ex_rd_num  (bus.ex_rd_num),
        .load_use   (load_use)
    );

    always_comb begin
        nxt_state     = state;
        nxt_mac_cnt   = mac_cnt;
        nxt_drain_cnt = drain_cnt;
        c_pc_stall    = 1'b0;
        c_ifid_stall  = 1'b0;
        c_ifid_flush  = 1'b0;
        c_idex_bubble = 1'b0;
        c_ex_hold     = 1'b0;
        c_mac_busy    = 1'b0;
        c_halted      = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.ex_branch_taken) begin
                    c_ifid_flush  = 1'b1;
                    c_idex_bubble = 1'b1;
                end else if (load_use) begin
                    c_pc_stall    = 1'b1;
                    c_ifid_stall  = 1'b1;
                    c_idex_bubble = 1'b1;
                end else if (bus.id_valid && bus.id_is_mac) begin
                    nxt_state   = ST_MAC_WAIT;
                    nxt_mac_cnt = MC_W'(MAC_LAT - 1);
                end else if (bus.id_valid && bus.id_is_halt) begin
                    nxt_state     = ST_HALT_DRAIN;
                    nxt_drain_cnt = DC_W'(DRAIN_CYCLES);
                end
            end
            ST_MAC_WAIT: begin
                c_pc_stall   = 1'b1;
                c_ifid_stall = 1'b1;
                c_ex_hold    = 1'b1;
                c_mac_busy   = 1'b1;
                nxt_mac_cnt  = mac_cnt - MC_W'(1);
                if (mac_cnt == MC_W'(1)) begin
                    nxt_state = ST_RUN;
                end
            end
            ST_HALT_DRAIN: begin
                c_pc_stall    = 1'b1;
                c_ifid_stall  = 1'b1;
                c_idex_bubble = 1'b1;
                // A taken branch here belongs to an older instruction and squashes the halt.
                if (bus.ex_branch_taken) begin
                    c_ifid_flush  = 1'b1;
                    nxt_state     = ST_RUN;
                    nxt_drain_cnt = '0;
                end else begin
                    nxt_drain_cnt = drain_cnt - DC_W'(1);
                    if (drain_cnt == DC_W'(1)) begin
                        nxt_state = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                c_pc_stall    = 1'b1;
                c_ifid_stall  = 1'b1;
                c_idex_bubble = 1'b1;
                c_halted      = 1'b1;
            end
            default: begin
                nxt_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            mac_cnt   <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= nxt_state;
            mac_cnt   <= nxt_mac_cnt;
            drain_cnt <= nxt_drain_cnt;
            if (c_pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Controls are decoded from live inputs, so gate them to keep every output low during reset.
    assign bus.pc_stall    = c_pc_stall    & ~rst;
    assign bus.ifid_stall  = c_ifid_stall  & ~rst;
    assign bus.ifid_flush  = c_ifid_flush  & ~rst;
    assign bus.idex_bubble = c_idex_bubble & ~rst;
    assign bus.ex_hold     = c_ex_hold     & ~rst;
    assign bus.mac_busy    = c_mac_busy    & ~rst;
    assign bus.halted      = c_halted      & ~rst;
    assign bus.stall_count = stall_cnt;

    mac_no_branch: assert property (@(posedge clk) disable iff (rst)
        (state == ST_MAC_WAIT) |-> !bus.ex_branch_taken);

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// tb/tb_arm_pipe_ctrl.sv - scoreboard bench for arm_pipe_ctrl against a cycles-remaining model
module tb_arm_pipe_ctrl;
    import arm_pipe_ctrl_pkg::*;

    localparam int MAC_LAT = 3;
    localparam int DRAIN   = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arm_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    arm_pipe_ctrl #(.MAC_LAT(MAC_LAT), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic pc, ifs, fl, bub, hold, busy, hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t  sb[$];
    string ph_q[$];
    string phase = "reset";
    int    n_vec = 0;
    int    n_bad = 0;

    int m_hold = 0;
    int m_drain = 0;
    bit m_halted = 0;
    int m_cnt = 0;

    task automatic model_cycle(output exp_t e);
        bit lu;
        e = '0;
        if (rst) begin
            m_hold = 0; m_drain = 0; m_halted = 0; m_cnt = 0;
            return;
        end
        e.cnt = CNT_W'(m_cnt);
        lu = 0;
        for (int i = 0; i < 3; i++)
            if (bus.id_rs_mask[i] && bus.id_rs_num[i] == bus.ex_rd_num) lu = 1;
        lu = lu && bus.id_valid && bus.ex_valid && bus.ex_is_load && bus.ex_rd_we;
        if (m_halted) begin
            e.pc = 1; e.ifs = 1; e.bub = 1; e.hlt = 1;
        end else if (m_hold > 0) begin
            e.pc = 1; e.ifs = 1; e.hold = 1; e.busy = 1;
            m_hold--;
        end else if (m_drain > 0) begin
            e.pc = 1; e.ifs = 1; e.bub = 1;
            if (bus.ex_branch_taken) begin
                e.fl = 1; m_drain = 0;
            end else begin
                m_drain--;
                if (m_drain == 0) m_halted = 1;
            end
        end else if (bus.ex_branch_taken) begin
            e.fl = 1; e.bub = 1;
        end else if (lu) begin
            e.pc = 1; e.ifs = 1; e.bub = 1;
        end else if (bus.id_valid && bus.id_is_mac) begin
            m_hold = MAC_LAT - 1;
        end else if (bus.id_valid && bus.id_is_halt) begin
            m_drain = DRAIN;
        end
        if (e.pc && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic apply(input logic r, input logic idv, input rs_nums_t nums, input rs_mask_t mask,
                         input logic mac, input logic hlt, input logic exv, input logic ld,
                         input logic we, input reg_num_t rd, input logic br);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus.id_valid = idv; bus.id_rs_num = nums; bus.id_rs_mask = mask;
        bus.id_is_mac = mac; bus.id_is_halt = hlt;
        bus.ex_valid = exv; bus.ex_is_load = ld; bus.ex_rd_we = we;
        bus.ex_rd_num = rd; bus.ex_branch_taken = br;
        model_cycle(e);
        sb.push_back(e);
        ph_q.push_back(phase);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, '0, '0, 0, 0, 0, 0, 0, 4'd0, 0);
    endtask

    task automatic rand_cycle(input int rst_per);
        logic br;
        rs_nums_t nums;
        br = ($urandom_range(0, 5) == 0) && (m_hold == 0);
        for (int i = 0; i < 3; i++) nums[i] = reg_num_t'($urandom_range(0, 3));
        apply(rst_per > 0 && $urandom_range(0, rst_per - 1) == 0,
              1'($urandom), nums, rs_mask_t'($urandom), $urandom_range(0, 5) == 0,
              $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
              reg_num_t'($urandom_range(0, 3)), br);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e, g;
        string p;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                p = ph_q.pop_front();
                g = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble,
                     bus.ex_hold, bus.mac_busy, bus.halted, bus.stall_count};
                n_vec++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL %s t=%0t got pc/ifs/fl/bub/hold/busy/hlt=%b%b%b%b%b%b%b cnt=%0d want %b%b%b%b%b%b%b cnt=%0d",
                             p, $time, g.pc, g.ifs, g.fl, g.bub, g.hold, g.busy, g.hlt, g.cnt,
                             e.pc, e.ifs, e.fl, e.bub, e.hold, e.busy, e.hlt, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        rst = 1'b1;
        bus.id_valid = 0; bus.id_rs_num = '0; bus.id_rs_mask = '0; bus.id_is_mac = 0;
        bus.id_is_halt = 0; bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_rd_we = 0;
        bus.ex_rd_num = '0; bus.ex_branch_taken = 0;
        apply(1, 1, {4'd0, 4'd3, 4'd0}, 3'b010, 0, 0, 1, 1, 1, 4'd3, 1);
        apply(1, 0, '0, '0, 0, 0, 0, 0, 0, 4'd0, 0);

        phase = "load_use";
        apply(0, 1, {4'd0, 4'd3, 4'd0}, 3'b010, 0, 0, 1, 1, 1, 4'd3, 0);
        idle(1);
        apply(0, 1, {4'd3, 4'd3, 4'd2}, 3'b001, 0, 0, 1, 1, 1, 4'd3, 0);
        idle(2);

        phase = "mac";
        apply(0, 1, {4'd0, 4'd1, 4'd2}, 3'b011, 1, 0, 0, 0, 0, 4'd0, 0);
        apply(0, 1, {4'd0, 4'd3, 4'd0}, 3'b010, 0, 0, 1, 1, 1, 4'd3, 0);
        apply(0, 1, {4'd0, 4'd3, 4'd0}, 3'b010, 0, 0, 1, 1, 1, 4'd3, 0);
        idle(2);

        phase = "branch_prio";
        apply(0, 1, {4'd0, 4'd3, 4'd0}, 3'b010, 1, 0, 1, 1, 1, 4'd3, 1);
        idle(2);

        phase = "halt";
        apply(0, 1, '0, '0, 0, 1, 0, 0, 0, 4'd0, 0);
        idle(4);
        for (int i = 0; i < 100; i++) rand_cycle(0);
        apply(1, 0, '0, '0, 0, 0, 0, 0, 0, 4'd0, 0);
        idle(1);

        phase = "halt_cancel";
        apply(0, 1, '0, '0, 0, 1, 0, 0, 0, 4'd0, 0);
        idle(1);
        apply(0, 0, '0, '0, 0, 0, 0, 0, 0, 4'd0, 1);
        idle(6);

        phase = "async_rst";
        apply(0, 1, '0, '0, 1, 0, 0, 0, 0, 4'd0, 0);
        idle(1);
        @(negedge clk);
        #1;
        chk("async_rst_busy_before", 32'(bus.mac_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", 32'({bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble,
                                     bus.ex_hold, bus.mac_busy, bus.halted, bus.stall_count}), 32'd0);
        apply(1, 0, '0, '0, 0, 0, 0, 0, 0, 4'd0, 0);

        phase = "saturate";
        for (int i = 0; i < 20; i++)
            apply(0, 1, {4'd5, 4'd0, 4'd0}, 3'b100, 0, 0, 1, 1, 1, 4'd5, 0);
        idle(2);

        phase = "random";
        for (int i = 0; i < 400; i++) rand_cycle(40);
        idle(2);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_queue t=%0t got=%0d pending want=0", $time, sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
